// File: rtl/up_down_pkg.sv
// Constants, types and output saturation shared by the 88.2K/44.1K rate converters.
// The interpolator and decimator both draw their coefficients and scaling from here.
package up_down_pkg;

  localparam int NTAP      = 126;
  localparam int HALF_TAPS = NTAP / 2;
  localparam int DW        = 28;
  localparam int COEF_W    = 32;
  localparam int ACCW      = 64;
  localparam int FRAME_LEN = 128;

  localparam logic [6:0] PHASE0_END = 7'(FRAME_LEN / 2 - 1);
  localparam logic [6:0] FRAME_END  = 7'(FRAME_LEN - 1);

  // Triangular kernel step: sum of the even (or odd) taps is just under 2^31.
  localparam logic [31:0] COEF_STEP = 32'd1065220;

  typedef logic [6:0] frame_idx_t;

  typedef enum logic {
    PHASE_EVEN = 1'b0,
    PHASE_ODD  = 1'b1
  } phase_e;

  // Takes acc[58:27]; clamps when the top six bits disagree (value outside 32 bits).
  function automatic logic signed [31:0] sat(input logic signed [63:0] acc);
    if (acc[63:58] == 6'b000000 || acc[63:58] == 6'b111111)
      return acc[58:27];
    else if (acc[63])
      return 32'sh8000_0000;
    else
      return 32'sh7FFF_FFFF;
  endfunction

endpackage

// File: rtl/up_882_mac.sv
// One channel of the interpolator: 63-entry delay line and a single serial MAC.
// Both phases walk the same delay entries; only the tap parity differs.
module up_882_mac #(
  parameter int DW   = up_down_pkg::DW,
  parameter int ACCW = up_down_pkg::ACCW
) (
  input  logic               bck882,
  input  logic               reset,
  input  logic        [6:0]  i,
  input  logic signed [31:0] tap,
  input  logic signed [31:0] x,
  output logic signed [31:0] pcm
);
  import up_down_pkg::*;

  localparam int PW = DW + COEF_W;

  logic signed [DW-1:0]   d [HALF_TAPS];
  logic signed [DW-1:0]   d_sel;
  logic signed [PW-1:0]   prod;
  logic signed [ACCW-1:0] acc;
  logic                   unused_x_lsb;

  assign unused_x_lsb = ^x[31-DW:0];

  // i[5:0] == 63 is the dump slot of each phase and has no delay entry.
  assign d_sel = (i[5:0] == 6'd63) ? '0 : d[i[5:0]];
  assign prod  = PW'(d_sel) * PW'(tap);

  always_ff @(posedge bck882 or posedge reset) begin
    if (reset) begin
      acc <= '0;
      pcm <= '0;
      for (int k = 0; k < HALF_TAPS; k++) d[k] <= '0;
    end else begin
      if (i == PHASE0_END || i == FRAME_END) begin
        pcm <= sat(acc);
        acc <= '0;
      end else begin
        acc <= acc + ACCW'(prod);
      end
      if (i == FRAME_END) begin
        d[0] <= x[31:32-DW];
        for (int k = 1; k < HALF_TAPS; k++) d[k] <= d[k-1];
      end
    end
  end

endmodule

// File: rtl/up_rom.sv
// Shared 126-tap coefficient ROM: symmetric triangular kernel, zero beyond the last tap.
// Purely combinational; the same table feeds the decimator.
module up_rom #(
  parameter int NTAP = up_down_pkg::NTAP
) (
  input  logic        [6:0]  addr,
  output logic signed [31:0] tap
);
  import up_down_pkg::*;

  logic [6:0] weight;

  always_comb begin
    weight = 7'd0;
    if (addr < 7'(NTAP / 2))
      weight = addr + 7'd1;
    else if (addr < 7'(NTAP))
      weight = 7'(NTAP) - addr;
    tap = $signed(32'(weight) * COEF_STEP);
  end

endmodule

// File: rtl/up_882.sv
// 2x polyphase interpolator 44.1K -> 88.2K: shared frame counter and ROM, one MAC per channel.
// Strobes are registered, so they rise together with the values they announce.
module up_882 #(
  parameter int NTAP = up_down_pkg::NTAP,
  parameter int DW   = up_down_pkg::DW,
  parameter int ACCW = up_down_pkg::ACCW
) (
  input  logic               bck882,
  input  logic               reset,
  input  logic signed [31:0] x_left,
  input  logic signed [31:0] x_right,
  output logic               in_ack,
  output logic signed [31:0] pcm_left,
  output logic signed [31:0] pcm_right,
  output logic               pcm_valid,
  output logic               pcm_phase
);
  import up_down_pkg::*;

  frame_idx_t         i;
  logic [6:0]         rom_addr;
  logic signed [31:0] rom_tap;

  always_ff @(posedge bck882 or posedge reset) begin
    if (reset) i <= '0;
    else       i <= i + 7'd1;
  end

  // in_ack is high in the cycle right after the edge that captured x_*.
  always_ff @(posedge bck882 or posedge reset) begin
    if (reset) begin
      in_ack    <= 1'b0;
      pcm_valid <= 1'b0;
      pcm_phase <= PHASE_EVEN;
    end else begin
      in_ack    <= (i == FRAME_END);
      pcm_valid <= (i == PHASE0_END) || (i == FRAME_END);
      if (i == PHASE0_END)
        pcm_phase <= PHASE_EVEN;
      else if (i == FRAME_END)
        pcm_phase <= PHASE_ODD;
    end
  end

  // Low bits of i pick the tap pair, i[6] picks even/odd parity.
  assign rom_addr = {i[5:0], i[6]};

  up_rom #(.NTAP(NTAP)) u_rom (
    .addr (rom_addr),
    .tap  (rom_tap)
  );

  up_882_mac #(.DW(DW), .ACCW(ACCW)) u_mac_left (
    .bck882 (bck882),
    .reset  (reset),
    .i      (i),
    .tap    (rom_tap),
    .x      (x_left),
    .pcm    (pcm_left)
  );

  up_882_mac #(.DW(DW), .ACCW(ACCW)) u_mac_right (
    .bck882 (bck882),
    .reset  (reset),
    .i      (i),
    .tap    (rom_tap),
    .x      (x_right),
    .pcm    (pcm_right)
  );

endmodule

// File: tb/tb_up_882.sv
// Scoreboard bench for up_882: a reference FIR predicts each frame's two outputs per channel.
// Covers idle, impulse, truncation, DC, saturation via a forced ROM, and mid-frame reset.
`timescale 1ns/1ps
module tb_up_882;

  localparam longint COEF       = 1065220;
  localparam longint FORCED_TAP = 268435456;

  typedef struct {
    logic [31:0] left;
    logic [31:0] right;
    logic        phase;
  } exp_t;

  logic               bck882 = 1'b0;
  logic               reset  = 1'b1;
  logic signed [31:0] x_left  = '0;
  logic signed [31:0] x_right = '0;
  logic               in_ack;
  logic signed [31:0] pcm_left;
  logic signed [31:0] pcm_right;
  logic               pcm_valid;
  logic               pcm_phase;

  int     checks = 0;
  int     errors = 0;
  int     since  = 0;
  bit     force_on = 1'b0;
  exp_t   sb[$];
  longint dl_l[63];
  longint dl_r[63];

  always #5 bck882 = ~bck882;

  up_882 dut (
    .bck882    (bck882),
    .reset     (reset),
    .x_left    (x_left),
    .x_right   (x_right),
    .in_ack    (in_ack),
    .pcm_left  (pcm_left),
    .pcm_right (pcm_right),
    .pcm_valid (pcm_valid),
    .pcm_phase (pcm_phase)
  );

  function automatic longint tbTap(int k);
    int w;
    if (k > 125) return 0;
    w = (k + 1 < 126 - k) ? k + 1 : 126 - k;
    return longint'(w) * COEF;
  endfunction

  function automatic logic [31:0] satModel(longint acc);
    longint s;
    if (acc > 64'sh03FF_FFFF_FFFF_FFFF) return 32'h7FFF_FFFF;
    if (acc < -64'sh0400_0000_0000_0000) return 32'h8000_0000;
    s = acc >>> 27;
    return s[31:0];
  endfunction

  task automatic checkOutput(string tag, logic [31:0] actual, logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
    end
  endtask

  task automatic finishBench();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  endtask

  task automatic clearModel();
    for (int j = 0; j < 63; j++) begin
      dl_l[j] = 0;
      dl_r[j] = 0;
    end
    sb.delete();
  endtask

  // Predicts both phase outputs of the frame that is just starting.
  task automatic pushFrame();
    for (int p = 0; p < 2; p++) begin
      longint al, ar, t;
      exp_t   e;
      al = 0;
      ar = 0;
      for (int j = 0; j < 63; j++) begin
        t  = force_on ? FORCED_TAP : tbTap(2 * j + p);
        al += dl_l[j] * t;
        ar += dl_r[j] * t;
      end
      e.left  = satModel(al);
      e.right = satModel(ar);
      e.phase = 1'(p);
      sb.push_back(e);
    end
  endtask

  // Runs one frame: holds x until the DUT acknowledges it, then shifts the model line.
  task automatic applyStimulus(logic [31:0] xl, logic [31:0] xr);
    bit seen;
    seen = 1'b0;
    pushFrame();
    x_left  = xl;
    x_right = xr;
    for (int n = 0; n < 200 && !seen; n++) begin
      @(negedge bck882);
      seen = in_ack;
    end
    if (!seen) begin
      checkOutput("ack_timeout", 32'(in_ack), 32'd1);
      finishBench();
    end
    for (int j = 62; j > 0; j--) begin
      dl_l[j] = dl_l[j-1];
      dl_r[j] = dl_r[j-1];
    end
    dl_l[0] = longint'($signed(xl[31:4]));
    dl_r[0] = longint'($signed(xr[31:4]));
  endtask

  task automatic checkResetState(string tag);
    checkOutput({tag, "_left"},  pcm_left,  32'd0);
    checkOutput({tag, "_right"}, pcm_right, 32'd0);
    checkOutput({tag, "_valid"}, 32'(pcm_valid), 32'd0);
    checkOutput({tag, "_phase"}, 32'(pcm_phase), 32'd0);
    checkOutput({tag, "_ack"},   32'(in_ack),    32'd0);
  endtask

  // Output monitor: pops one prediction per pcm_valid and checks strobe spacing.
  always @(negedge bck882) begin
    if (reset) begin
      since = 0;
    end else begin
      since++;
      if (pcm_valid) begin
        if (sb.size() == 0) begin
          checkOutput("sb_empty", 32'(sb.size()), 32'd1);
        end else begin
          exp_t e;
          e = sb.pop_front();
          checkOutput("pcm_left",  pcm_left,  e.left);
          checkOutput("pcm_right", pcm_right, e.right);
          checkOutput("pcm_phase", 32'(pcm_phase), 32'(e.phase));
          checkOutput("in_ack",    32'(in_ack),    32'(e.phase));
          checkOutput("spacing",   32'(since),     32'd64);
        end
        since = 0;
      end else if (in_ack) begin
        checkOutput("ack_stray", 32'(in_ack), 32'd0);
      end
    end
  end

  initial begin
    clearModel();
    repeat (2) @(negedge bck882);
    #1;
    checkResetState("reset");
    @(negedge bck882);
    #2 reset = 1'b0;

    $display("[TB] idle");
    repeat (3) applyStimulus(32'h0, 32'h0);

    $display("[TB] truncation and impulse");
    applyStimulus(32'h0000_000F, 32'h0);
    applyStimulus(32'h1000_0000, 32'h0);
    repeat (64) applyStimulus(32'h0, 32'h0);

    $display("[TB] dc");
    repeat (70) applyStimulus(32'h0800_0000, 32'h0800_0000);

    $display("[TB] saturation");
    force dut.rom_tap = 32'sh1000_0000;
    force_on = 1'b1;
    repeat (66) applyStimulus(32'h7FFF_FFFF, 32'h7FFF_FFFF);
    repeat (66) applyStimulus(32'h8000_0000, 32'h8000_0000);
    release dut.rom_tap;
    force_on = 1'b0;

    $display("[TB] mid-frame reset");
    x_left  = 32'h0800_0000;
    x_right = 32'h0800_0000;
    repeat (40) @(negedge bck882);
    reset = 1'b1;
    #1;
    checkResetState("midreset");
    clearModel();
    x_left  = '0;
    x_right = '0;
    @(negedge bck882);
    #2 reset = 1'b0;
    repeat (2) applyStimulus(32'h0, 32'h0);

    finishBench();
  end

endmodule
